// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity encodings,
// default frame geometry and the 3-sample majority vote.
package uart_rx_frame_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_OVERSAMPLE = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchronizer, per-cell sample counter and a
// mid-cell 3-sample majority vote.
module uart_rx_sampler
    import uart_rx_frame_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic CLK,
    input  logic RST,
    input  logic RX_IN,
    input  logic run_i,
    output logic rx_s_o,
    output logic bit_val_o,
    output logic sample_strobe_o,
    output logic cell_end_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] C_MM1  = CW'(M - 1);
    localparam logic [CW-1:0] C_M    = CW'(M);
    localparam logic [CW-1:0] C_MP1  = CW'(M + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          samp_a_q, samp_b_q;

    // The counter only runs while the FSM is (or is about to be) inside a frame,
    // so it is back at 0 in every IDLE cycle.
    always_comb begin
        cnt_d = '0;
        if (run_i) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            cnt_q    <= '0;
            samp_a_q <= 1'b0;
            samp_b_q <= 1'b0;
        end else begin
            sync1_q <= RX_IN;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            if (cnt_q == C_MM1) samp_a_q <= sync2_q;
            if (cnt_q == C_M)   samp_b_q <= sync2_q;
        end
    end

    assign rx_s_o          = sync2_q;
    assign bit_val_o       = majority3(samp_a_q, samp_b_q, sync2_q);
    assign sample_strobe_o = (cnt_q == C_MP1);
    assign cell_end_o      = (cnt_q == C_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start detect, LSB-first deserializer, optional parity and
// stop checks, with 1-cycle result strobes.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_IN,
    input  logic             parity_enable,
    input  logic             parity_type,
    output logic [WIDTH-1:0] P_DATA,
    output logic             Data_Valid,
    output logic             parity_error,
    output logic             stop_error,
    output logic             busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             pen_q, pen_d;
    logic             ptype_q, ptype_d;
    logic             pmis_q, pmis_d;
    logic             dv_q, dv_d;
    logic             perr_q, perr_d;
    logic             serr_q, serr_d;
    logic             rx_s, bit_val, samp_stb, cell_end, run;

    assign run = (state_d != IDLE);

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .CLK             (CLK),
        .RST             (RST),
        .RX_IN           (RX_IN),
        .run_i           (run),
        .rx_s_o          (rx_s),
        .bit_val_o       (bit_val),
        .sample_strobe_o (samp_stb),
        .cell_end_o      (cell_end)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pdata_d   = pdata_q;
        pen_d     = pen_q;
        ptype_d   = ptype_q;
        pmis_d    = pmis_q;
        dv_d      = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    pen_d   = parity_enable;
                    ptype_d = parity_type;
                    pmis_d  = 1'b0;
                end
            end
            START: begin
                if (samp_stb && bit_val) begin
                    state_d = IDLE;
                end else if (cell_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (samp_stb) shift_d = {bit_val, shift_q[WIDTH-1:1]};
                if (cell_end) begin
                    if (bit_cnt_q == BW'(WIDTH - 1)) state_d = pen_q ? PARITY : STOP;
                    else                             bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (samp_stb) begin
                    case (ptype_q)
                        PAR_EVEN: pmis_d = bit_val ^ (^shift_q);
                        default:  pmis_d = bit_val ^ (~^shift_q);
                    endcase
                end
                if (cell_end) state_d = STOP;
            end
            STOP: begin
                // Leave at mid-cell so a zero-idle next start edge is not missed.
                if (samp_stb) begin
                    state_d = IDLE;
                    serr_d  = !bit_val;
                    perr_d  = pen_q && pmis_q;
                    if (bit_val && !(pen_q && pmis_q)) begin
                        pdata_d = shift_q;
                        dv_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pdata_q   <= '0;
            pen_q     <= 1'b0;
            ptype_q   <= 1'b0;
            pmis_q    <= 1'b0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pdata_q   <= pdata_d;
            pen_q     <= pen_d;
            ptype_q   <= ptype_d;
            pmis_q    <= pmis_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
        end
    end

    assign P_DATA       = pdata_q;
    assign Data_Valid   = dv_q;
    assign parity_error = perr_q;
    assign stop_error   = serr_q;
    assign busy         = (state_q != IDLE);

endmodule
